// File: rtl/cam_fb_writer.sv
// cam_fb_writer: camera pixel stream to ping-pong frame-buffer write port.
// Synchronises VSYNC, counts pixels into linear addresses, checks each
// frame's pixel count at frame end and swaps buffers only on good frames.
// Optional build macro FB_DECIMATE_EN: keep only even-x/even-y pixels,
// producing a half-width, half-height image.
//
// Handshake: i_pix_valid is a one-cycle strobe with no back-pressure; each
// accepted pixel appears on the write port exactly one cycle later with
// o_wr_en high for that single cycle.
module cam_fb_writer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              i_pclk,
    input  logic              i_rstn,
    input  logic              i_vsync,
    input  logic [11:0]       i_pix_data,
    input  logic              i_pix_valid,
    input  logic              i_enable,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [11:0]       o_wr_data,
    output logic              o_wr_buf,
    output logic              o_rd_buf,
    output logic              o_frame_done,
    output logic              o_frame_err
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = $clog2(V_ACTIVE + 1);
`ifdef FB_DECIMATE_EN
    localparam int FRAME_WORDS = (H_ACTIVE / 2) * (V_ACTIVE / 2);
`else
    localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE;
`endif
    // One extra bit so a full count never wraps before the end-of-frame check.
    localparam logic [ADDR_W:0] FRAME_CNT = (ADDR_W + 1)'(FRAME_WORDS);
    localparam logic [XW-1:0]   X_LAST    = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0]   Y_END     = YW'(V_ACTIVE);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t          state_q, state_d;
    logic            vs_s1, vs_s2, vs_s3;
    logic            fs, fe;
    logic            start, capture, frame_end;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            wr_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic            keep;
    logic            good_d, bad_d;

    // VSYNC synchroniser plus one delay stage for edge detection.
    always_ff @(posedge i_pclk or negedge i_rstn) begin
        if (!i_rstn) begin
            vs_s1 <= 1'b0;
            vs_s2 <= 1'b0;
            vs_s3 <= 1'b0;
        end else begin
            vs_s1 <= i_vsync;
            vs_s2 <= vs_s1;
            vs_s3 <= vs_s2;
        end
    end

    assign fs        = vs_s3 & ~vs_s2;
    assign fe        = ~vs_s3 & vs_s2;
    assign start     = (state_q == IDLE) && fs && i_enable;
    assign capture   = (state_q == ACTIVE) || start;
    assign frame_end = (state_q == ACTIVE) && fe;

    // FSM state register.
    always_ff @(posedge i_pclk or negedge i_rstn) begin
        if (!i_rstn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // FSM next-state: enable is only looked at on the frame-start edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fs && i_enable) state_d = ACTIVE;
            ACTIVE:  if (fe)             state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: counter updates, write decision and frame verdict.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        wr_d      = 1'b0;
        wr_addr_d = cnt_q[ADDR_W-1:0];
        keep      = 1'b1;
        if (start) begin
            x_d   = '0;
            y_d   = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end
        if (capture && i_pix_valid) begin
            if (y_d < Y_END) begin
`ifdef FB_DECIMATE_EN
                keep = ~x_d[0] & ~y_d[0];
`else
                keep = 1'b1;
`endif
                wr_d      = keep;
                wr_addr_d = cnt_d[ADDR_W-1:0];
                if (keep) cnt_d = cnt_d + 1'b1;
                if (x_d == X_LAST) begin
                    x_d = '0;
                    y_d = y_d + 1'b1;
                end else begin
                    x_d = x_d + 1'b1;
                end
            end else begin
                ovf_d = 1'b1;
            end
        end
        // The verdict includes a pixel arriving in the frame-end cycle.
        good_d = frame_end && !ovf_d && (cnt_d == FRAME_CNT);
        bad_d  = frame_end && !good_d;
    end

    // Registered counters, write port and buffer bookkeeping.
    always_ff @(posedge i_pclk or negedge i_rstn) begin
        if (!i_rstn) begin
            x_q          <= '0;
            y_q          <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_wr_buf     <= 1'b0;
            o_rd_buf     <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            o_wr_en      <= wr_d;
            o_frame_done <= frame_end;
            if (wr_d) begin
                o_wr_addr <= wr_addr_d;
                o_wr_data <= i_pix_data;
            end
            // A bad frame leaves both indices alone so it gets overwritten.
            if (good_d) begin
                o_rd_buf <= o_wr_buf;
                o_wr_buf <= ~o_wr_buf;
            end
            if (bad_d) o_frame_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cam_fb_writer.sv
// tb_cam_fb_writer: directed vectors for cam_fb_writer on a tiny frame.
module tb_cam_fb_writer;

    localparam int H = 4;
`ifdef FB_DECIMATE_EN
    localparam int V = 4;
`else
    localparam int V = 3;
`endif
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vsync;
    logic [11:0]   pix_data;
    logic          pix_valid;
    logic          enable;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;
    logic          wr_buf;
    logic          rd_buf;
    logic          frame_done;
    logic          frame_err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [16:0] exp_q[$];

    typedef struct {
        logic [11:0]   data;
        logic          exp_en;
        logic [AW-1:0] exp_addr;
    } vec_t;
    vec_t tbl[16];

    cam_fb_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .i_pclk      (clk),
        .i_rstn      (rst_n),
        .i_vsync     (vsync),
        .i_pix_data  (pix_data),
        .i_pix_valid (pix_valid),
        .i_enable    (enable),
        .o_wr_en     (wr_en),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .o_wr_buf    (wr_buf),
        .o_rd_buf    (rd_buf),
        .o_frame_done(frame_done),
        .o_frame_err (frame_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // scoreboard: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got buf %0d addr %0h data %0h expected none",
                         wr_buf, wr_addr, wr_data);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                if ({wr_buf, wr_addr, wr_data} !== e) begin
                    errors++;
                    $display("FAIL write got %0h expected %0h", {wr_buf, wr_addr, wr_data}, e);
                end
            end
        end
    end

    // driver tasks
    task automatic send_pix(input logic [11:0] d, input logic en, input logic [AW-1:0] a,
                            input logic b);
        pix_valid = 1'b1;
        pix_data  = d;
        if (en) exp_q.push_back({b, a, d});
        tick();
        pix_valid = 1'b0;
        chk("wr_en_latency", 32'(wr_en), 32'(en));
    endtask

    task automatic run_tbl(input int n, input logic b);
        for (int i = 0; i < n; i++) send_pix(tbl[i].data, tbl[i].exp_en, tbl[i].exp_addr, b);
    endtask

    // after return the next cycle is the synchronised frame-start cycle
    task automatic fs_edge();
        vsync = 1'b0;
        tick();
        tick();
    endtask

    task automatic frame_start();
        fs_edge();
        tick();
    endtask

    // returns on the cycle where o_frame_done is expected high
    task automatic frame_end();
        vsync = 1'b1;
        tick();
        tick();
        tick();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
        chk({tag, "_wr_data"}, 32'(wr_data), 0);
        chk({tag, "_wr_buf"}, 32'(wr_buf), 0);
        chk({tag, "_rd_buf"}, 32'(rd_buf), 0);
        chk({tag, "_done"}, 32'(frame_done), 0);
        chk({tag, "_err"}, 32'(frame_err), 0);
    endtask

    task automatic chk_end(input string tag, input logic done, input logic rb,
                           input logic wb, input logic err);
        chk({tag, "_done"}, 32'(frame_done), 32'(done));
        chk({tag, "_rd_buf"}, 32'(rd_buf), 32'(rb));
        chk({tag, "_wr_buf"}, 32'(wr_buf), 32'(wb));
        chk({tag, "_err"}, 32'(frame_err), 32'(err));
        tick();
        chk({tag, "_done_clear"}, 32'(frame_done), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        vsync     = 1'b1;
        pix_valid = 1'b0;
        pix_data  = '0;
        enable    = 1'b1;
        repeat (3) tick();
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (5) tick();

`ifdef FB_DECIMATE_EN
        // 4x4 frame: only pixels 0, 2, 8, 10 survive decimation
        for (int i = 0; i < 16; i++) tbl[i] = '{12'(i + 1), 1'b0, '0};
        tbl[0]  = '{12'h001, 1'b1, 4'd0};
        tbl[2]  = '{12'h003, 1'b1, 4'd1};
        tbl[8]  = '{12'h009, 1'b1, 4'd2};
        tbl[10] = '{12'h00B, 1'b1, 4'd3};
        frame_start();
        run_tbl(16, 1'b0);
        frame_end();
        chk_end("decim", 1'b1, 1'b0, 1'b1, 1'b0);
        chk("done_count", 32'(done_cnt), 1);
`else
        // full frame table: data 1..12 to addr 0..11, 13th pixel overflows
        for (int i = 0; i < 12; i++) tbl[i] = '{12'(i + 1), 1'b1, AW'(i)};
        tbl[12] = '{12'h00D, 1'b0, '0};

        // good frame in buffer 0
        frame_start();
        run_tbl(12, 1'b0);
        frame_end();
        chk_end("good", 1'b1, 1'b0, 1'b1, 1'b0);

        // short frame in buffer 1: error, no swap
        repeat (3) tick();
        frame_start();
        run_tbl(11, 1'b1);
        frame_end();
        chk_end("short", 1'b1, 1'b0, 1'b1, 1'b1);

        // long frame, same buffer again: 13th pixel dropped, no swap
        repeat (3) tick();
        frame_start();
        run_tbl(13, 1'b1);
        frame_end();
        chk_end("long", 1'b1, 1'b0, 1'b1, 1'b1);

        // disabled at frame start: nothing written, no done pulse
        repeat (3) tick();
        enable = 1'b0;
        frame_start();
        for (int i = 0; i < 12; i++) send_pix(12'h0F0, 1'b0, '0, 1'b0);
        frame_end();
        chk("disabled_done", 32'(frame_done), 0);
        enable = 1'b1;

        // pixel coincident with frame start lands at addr 0; good frame swaps
        repeat (3) tick();
        fs_edge();
        send_pix(12'h0AB, 1'b1, 4'd0, 1'b1);
        for (int i = 1; i < 12; i++) send_pix(12'h100 + 12'(i), 1'b1, AW'(i), 1'b1);
        frame_end();
        chk_end("coinc", 1'b1, 1'b1, 1'b0, 1'b1);

        // reset after 5 pixels of a frame in buffer 0
        repeat (3) tick();
        frame_start();
        for (int i = 0; i < 5; i++) send_pix(12'h200 + 12'(i), 1'b1, AW'(i), 1'b0);
        @(negedge clk);
        #1;
        chk("pre_reset_wr_en", 32'(wr_en), 1);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        vsync = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        frame_start();
        for (int i = 0; i < 12; i++) send_pix(12'h300 + 12'(i), 1'b1, AW'(i), 1'b0);
        frame_end();
        chk_end("after_rst", 1'b1, 1'b0, 1'b1, 1'b0);

        chk("done_count", 32'(done_cnt), 5);
`endif
        repeat (2) tick();
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_fb_writer.md
Name: cam_fb_writer

Overview:
- Consumes 12-bit RGB444 pixels (valid-strobed) from the camera capture stage in the pixel-clock domain.
- Generates linear frame-buffer write addresses, drives a BRAM write port, and tracks frame boundaries from VSYNC.
- Ping-pongs between two frame buffers and reports per-frame pixel-count errors.
- Sits between camera capture and the dual-port frame buffer read by the VGA side.

Parameters:
- H_ACTIVE, 640: pixels per line.
- V_ACTIVE, 480: lines per frame.
- ADDR_W, 19: write address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.

Ports:
- i_pclk  in  1  pixel clock; all logic on rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_vsync  in  1  raw camera VSYNC; high = blanking.
- i_pix_data  in  12  pixel {RRRR,GGGG,BBBB}.
- i_pix_valid  in  1  one-cycle strobe per pixel.
- i_enable  in  1  capture enable, sampled only at frame start.
- o_wr_en  out  1  frame-buffer write strobe.
- o_wr_addr  out  ADDR_W  linear write address (y*H_ACTIVE + x).
- o_wr_data  out  12  write data.
- o_wr_buf  out  1  target buffer index (0/1).
- o_rd_buf  out  1  buffer holding the last complete good frame.
- o_frame_done  out  1  one-cycle pulse at end of a captured frame.
- o_frame_err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (async, i_rstn=0): all outputs 0; state IDLE; x, y, addr = 0; VSYNC sync flops = 0.
- VSYNC path:
  - 2-flop synchroniser, then edge detection.
  - fs = falling edge (frame start); fe = rising edge (frame end).
- FSM:
  - IDLE: on fs with i_enable=1 -> ACTIVE; clear x, y, addr and the cycle's overflow flag.
  - IDLE: fs with i_enable=0 is ignored.
  - ACTIVE: on fe -> IDLE; pulse o_frame_done the next cycle.
- Pixel handling in ACTIVE:
  - Each i_pix_valid with y < V_ACTIVE: register o_wr_en=1, o_wr_addr=addr, o_wr_data=i_pix_data, o_wr_buf=current buffer.
  - Write latency: exactly 1 cycle from i_pix_valid.
  - Then addr += 1 and x += 1. When x==H_ACTIVE-1: x wraps to 0 and y increments.
- Overflow: i_pix_valid with y == V_ACTIVE -> no write; addr and y hold; overflow flag set.
- Frame check at fe:
  - Good frame: addr == H_ACTIVE*V_ACTIVE and no overflow. Set o_rd_buf <= o_wr_buf and toggle the write buffer for the next frame.
  - Bad frame: set o_frame_err=1. Buffers unchanged, so the next frame overwrites the same buffer and the display never shows a torn frame.
- Short line: x and y count valids only, with no HREF input, so a short line shifts later pixels. This is detected only via the end-of-frame count.
- Simultaneous events:
  - fs + i_pix_valid in the same cycle (IDLE->ACTIVE): the pixel is written at addr 0; counters become x=1, addr=1.
  - fe + i_pix_valid in the same cycle: the pixel is written and counted before the frame check.
- Outside ACTIVE: i_pix_valid is ignored and o_wr_en=0.
- i_enable deasserted mid-frame: the current frame completes normally; the next fs stays in IDLE.
- Reset mid-frame: immediate return to IDLE. The buffer indices revert to 0 and o_rd_buf=0; the frame in progress is discarded.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro FB_DECIMATE_EN.
- When defined:
  - Write only pixels with even x and even y, giving an (H_ACTIVE/2)x(V_ACTIVE/2) image.
  - addr increments only on written pixels.
  - Good-frame count = (H_ACTIVE/2)*(V_ACTIVE/2).
  - x and y still count every valid for line tracking.
- When undefined: full-resolution behaviour as above.

Test Plan:
- H_ACTIVE=4, V_ACTIVE=3; reset; fs; 12 valids with data 0x001..0x00C; fe -> 12 writes at addr 0..11, 1-cycle latency. o_frame_done pulses once, o_rd_buf=0, next o_wr_buf=1, o_frame_err=0.
- Same params, 11 valids then fe -> o_frame_err=1; o_rd_buf unchanged; next frame written to the same buffer.
- 13 valids -> 12 writes only; 13th dropped with o_wr_en=0; o_frame_err=1 at fe.
- i_enable=0 at fs, then 12 valids -> no writes, no o_frame_done. i_enable=1 at the next fs -> normal capture.
- Valid in the same cycle as the fs edge -> written at addr 0. Drop i_rstn mid-frame after 5 pixels -> all outputs 0 immediately; the next fs restarts at addr 0 in buffer 0.
- FB_DECIMATE_EN, 4x4 frame, 16 valids -> 4 writes (pixels 0, 2, 8, 10) at addr 0..3; frame good.
